// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, reusing one full_adder cell
// with a carry register; operands and result move over valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, s_sr_q, s_sr_d;
    logic             carry_q, carry_d, fa_sum;
    logic [CW-1:0]    cnt_q;

    full_adder u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .sum (fa_sum),
        .cout(carry_d)
    );

    assign s_sr_d    = {fa_sum, s_sr_q[WIDTH-1:1]};
    assign in_ready  = state_q == IDLE && !rst;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_sr_q  <= a;
                    b_sr_q  <= b;
                    carry_q <= cin;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    s_sr_q  <= s_sr_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    // result registers only move on the last bit, so they hold through IDLE/RUN
                    if (cnt_q == LAST) begin
                        sum     <= s_sr_d;
                        cout    <= carry_d;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, exhaustive (WIDTH=2) and random (WIDTH=8/16) checks of serial_adder
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic go = 1'b0;
    logic fin [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    logic       iv8 = 1'b0, or8 = 1'b0, cin8 = 1'b0, rdy8, ov8, co8, busy8;
    logic [7:0] a8 = '0, b8 = '0, s8;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8), .cin(cin8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(busy8)
    );

    logic       iv2 = 1'b0, or2 = 1'b0, c2 = 1'b0, rdy2, ov2, co2, busy2;
    logic [1:0] a2 = '0, b2 = '0, s2;

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .a(a2), .b(b2), .cin(c2),
        .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .busy(busy2)
    );

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int stall);
        logic [8:0] exp;
        int n;
        exp = 9'(a) + 9'(b) + 9'(c);
        @(negedge clk);
        check("in_ready before accept", rdy8, 1);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
        n = 0;
        while (!ov8 && n < 40) begin
            check("busy during run", busy8, 1);
            @(negedge clk);
            n++;
        end
        check("latency edges", n, 8);
        check("result {cout,sum}", {co8, s8}, exp);
        repeat (stall) begin
            iv8 = 1'b1;
            @(negedge clk);
            check("held {out_valid,cout,sum}", {ov8, co8, s8}, {1'b1, exp});
            check("in_ready low in done", rdy8, 0);
        end
        iv8 = 1'b1; or8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b0;
        check("idle after out_ready {busy,ov,rdy}", {busy8, ov8, rdy8}, 3'b001);
    endtask

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : rnd
            localparam int W = g == 0 ? 8 : 16;
            localparam int N = 1000;
            logic         iv = 1'b0, ordy = 1'b0, c = 1'b0, rdy, ov, co, bsy;
            logic [W-1:0] ra = '0, rb = '0, s;
            logic [W:0]   q [$];

            serial_adder #(.WIDTH(W)) dut (
                .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy), .a(ra), .b(rb), .cin(c),
                .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .busy(bsy)
            );

            initial begin : drv
                int   n;
                logic acc;
                wait (go);
                for (int k = 0; k < N; k++) begin
                    acc = 1'b0;
                    n = 0;
                    while (!acc && n < 400) begin
                        @(negedge clk);
                        ra = W'($urandom);
                        rb = W'($urandom);
                        c  = 1'($urandom);
                        iv = $urandom_range(0, 3) != 0;
                        if (iv && rdy) begin
                            q.push_back((W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(c));
                            acc = 1'b1;
                        end
                        n++;
                    end
                    check("rnd accept within bound", acc, 1);
                end
                @(negedge clk);
                iv = 1'b0;
            end

            initial begin : mon
                int         n, got, extra;
                logic [W:0] e;
                wait (go);
                n = 0;
                got = 0;
                while (got < N && n < N * 100) begin
                    @(negedge clk);
                    ordy = 1'($urandom);
                    if (ov && ordy) begin
                        check("rnd result pending", q.size() != 0, 1);
                        e = q.size() != 0 ? q.pop_front() : '1;
                        check("rnd {cout,sum}", {co, s}, e);
                        got++;
                    end
                    n++;
                end
                check("rnd result count", got, N);
                ordy = 1'b1;
                extra = 0;
                repeat (3 * W) begin
                    @(negedge clk);
                    if (ov) extra++;
                end
                check("rnd duplicated results", extra, 0);
                check("rnd lost transactions", q.size(), 0);
                fin[g] = 1'b1;
            end
        end
    endgenerate

    initial begin
        int         n, got, prev;
        logic [2:0] e2;
        @(negedge clk);
        check("reset in_ready", rdy8, 0);
        check("reset {cout,sum}", {co8, s8}, 0);
        check("reset {busy,out_valid}", {busy8, ov8}, 0);
        rst = 1'b0;
        #1;
        check("in_ready after reset release", rdy8, 1);
        run8(8'h00, 8'h00, 1'b0, 0);
        run8(8'hFF, 8'h01, 1'b0, 0);
        run8(8'hA5, 8'h5A, 1'b1, 0);
        run8(8'hFF, 8'hFF, 1'b1, 0);
        run8(8'h3C, 8'h0F, 1'b0, 5);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy before abort", busy8, 1);
        rst = 1'b1;
        #1;
        check("abort {busy,out_valid,sum}", {busy8, ov8, s8}, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (ov8) n++;
        end
        check("no out_valid for aborted op", n, 0);
        run8(8'h12, 8'h34, 1'b0, 0);
        or2 = 1'b1;
        prev = 0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (!rdy2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (i > 0) check("w2 accept spacing", cyc - prev, 4);
            prev = cyc;
            {a2, b2, c2} = 5'(i);
            e2 = 3'(a2) + 3'(b2) + 3'(c2);
            iv2 = 1'b1;
            @(negedge clk);
            iv2 = 1'b0;
            n = 0;
            got = 0;
            while (!rdy2 && n < 20) begin
                if (ov2) begin
                    check("w2 {cout,sum}", {co2, s2}, e2);
                    got++;
                end
                @(negedge clk);
                n++;
            end
            check("w2 one result per op", got, 1);
        end
        or2 = 1'b0;
        go = 1'b1;
        n = 0;
        while (!(fin[0] && fin[1]) && n < 80000) begin
            @(negedge clk);
            n++;
        end
        check("random runs completed", fin[0] && fin[1], 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
